seq_code_detector: RTL and testbench

Parametrised successor to the fixed four-colour code detector. Arms on `Start`, then checks a sequence of one-hot button presses against a run-time programmable code of `CODE_LEN` entries over `NUM_COLORS` channels. Pulses `U` on a full match and `Fail` on a wrong press. Sits between the debounced button front-end and the door/unlock controller; an optional lockout stage throttles repeated failures.

---
 rtl/seq_code_detector.sv | 158 +++++++++++++++
 tb/tb_seq_code_detector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_code_detector.sv
// Programmable one-hot button code detector: arms on Start, pulses U on a full match, Fail on a wrong press.
// Optional lockout after repeated failures is enabled by defining SEQ_CODE_LOCKOUT_EN.
module seq_code_detector #(
    parameter int NUM_COLORS  = 3,
    parameter int CODE_LEN    = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Start,
    input  logic [NUM_COLORS-1:0]         Btn,
    input  logic                          CodeWe,
    input  logic [$clog2(CODE_LEN)-1:0]   CodeIdx,
    input  logic [NUM_COLORS-1:0]         CodeVal,
    output logic                          U,
    output logic                          Fail,
    output logic                          Busy,
    output logic                          Locked
);
    localparam int IDX_W = $clog2(CODE_LEN);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_DONE    = 3'd2;
    localparam logic [2:0] ST_FAILED  = 3'd3;
`ifdef SEQ_CODE_LOCKOUT_EN
    localparam logic [2:0] ST_LOCKOUT = 3'd4;
    localparam int FC_W = $clog2(MAX_FAIL + 1);
    localparam int LC_W = $clog2(LOCK_CYCLES + 1);
`endif

    if (NUM_COLORS < 2 || CODE_LEN < 2 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_bad_params
        $error("seq_code_detector: illegal parameter value");
    end

    function automatic logic [CODE_LEN-1:0][NUM_COLORS-1:0] default_code();
        logic [CODE_LEN-1:0][NUM_COLORS-1:0] c;
        for (int i = 0; i < CODE_LEN; i++) begin
            c[i] = '0;
            c[i][i % NUM_COLORS] = 1'b1;
        end
        return c;
    endfunction

    logic [2:0]                           state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [CODE_LEN-1:0][NUM_COLORS-1:0]  code_q, code_d;
`ifdef SEQ_CODE_LOCKOUT_EN
    logic [FC_W-1:0]                      fail_cnt_q, fail_cnt_d;
    logic [LC_W-1:0]                      lock_cnt_q, lock_cnt_d;
`endif

    logic idx_ok;
    logic btn_hit;
    logic idx_last;

    assign idx_ok   = 32'(CodeIdx) < CODE_LEN;
    // A press must be one-hot, so zero or multi-hot stored entries never match.
    assign btn_hit  = $onehot(Btn) && (Btn == code_q[idx_q]);
    assign idx_last = idx_q == IDX_W'(CODE_LEN - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
`ifdef SEQ_CODE_LOCKOUT_EN
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (CodeWe && idx_ok) code_d[CodeIdx] = CodeVal;
                if (Start) begin
                    state_d = ST_ARMED;
                    idx_d   = '0;
                end
            end
            ST_ARMED: begin
                if (Btn != '0) begin
                    if (btn_hit) begin
                        if (idx_last) begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        state_d = ST_FAILED;
                        idx_d   = '0;
`ifdef SEQ_CODE_LOCKOUT_EN
                        if (fail_cnt_q != FC_W'(MAX_FAIL)) fail_cnt_d = fail_cnt_q + FC_W'(1);
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef SEQ_CODE_LOCKOUT_EN
                fail_cnt_d = '0;
`endif
            end
            ST_FAILED: begin
`ifdef SEQ_CODE_LOCKOUT_EN
                if (fail_cnt_q == FC_W'(MAX_FAIL)) begin
                    state_d    = ST_LOCKOUT;
                    lock_cnt_d = LC_W'(LOCK_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef SEQ_CODE_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LC_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            code_q  <= default_code();
`ifdef SEQ_CODE_LOCKOUT_EN
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
`ifdef SEQ_CODE_LOCKOUT_EN
            fail_cnt_q <= fail_cnt_d;
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign U    = state_q == ST_DONE;
    assign Fail = state_q == ST_FAILED;
    assign Busy = state_q == ST_ARMED;
`ifdef SEQ_CODE_LOCKOUT_EN
    assign Locked = state_q == ST_LOCKOUT;
`else
    assign Locked = 1'b0;
`endif

endmodule

// File: tb/tb_seq_code_detector.sv
// Bench for seq_code_detector: per-cycle vectors whose expected {U,Fail,Busy,Locked}
// go through a scoreboard queue and are checked one cycle after the inputs are sampled.
module tb_seq_code_detector;
    logic       clk = 1'b0;
    logic       rst, start, we;
    logic [2:0] btn, val;
    logic [1:0] idx;
    logic       u, fail, busy, locked;

    always #5 clk = ~clk;

    seq_code_detector dut (
        .Clk(clk), .Rst(rst), .Start(start), .Btn(btn), .CodeWe(we),
        .CodeIdx(idx), .CodeVal(val), .U(u), .Fail(fail), .Busy(busy), .Locked(locked)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       start;
        logic [2:0] btn;
        logic       we;
        logic [1:0] idx;
        logic [2:0] val;
        logic [3:0] exp;   // {U, Fail, Busy, Locked} after the sampling edge
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb_exp[$];
    string      sb_name[$];
    int         total = 0;
    int         bad   = 0;

    function automatic vec_t mk(input string n, input logic r, input logic s, input logic [2:0] b,
                                input logic w, input logic [1:0] i, input logic [2:0] v,
                                input logic [3:0] e);
        vec_t x;
        x.name = n; x.rst = r; x.start = s; x.btn = b; x.we = w; x.idx = i; x.val = v; x.exp = e;
        return x;
    endfunction

    function automatic void rs(input string n);
        vecs.push_back(mk(n, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0000));
    endfunction
    function automatic void st(input string n, input logic [3:0] e);
        vecs.push_back(mk(n, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, e));
    endfunction
    function automatic void pr(input string n, input logic [2:0] b, input logic [3:0] e);
        vecs.push_back(mk(n, 1'b0, 1'b0, b, 1'b0, 2'd0, 3'b000, e));
    endfunction
    function automatic void wr(input string n, input logic [1:0] i, input logic [2:0] v);
        vecs.push_back(mk(n, 1'b0, 1'b0, 3'b000, 1'b1, i, v, 4'b0000));
    endfunction

    task automatic apply(input vec_t v);
        logic [3:0] e, got;
        string      n;
        @(negedge clk);
        rst = v.rst; start = v.start; btn = v.btn; we = v.we; idx = v.idx; val = v.val;
        sb_exp.push_back(v.exp);
        sb_name.push_back(v.name);
        @(posedge clk);
        #1;
        got = {u, fail, busy, locked};
        e   = sb_exp.pop_front();
        n   = sb_name.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got {U,Fail,Busy,Locked}=%b want=%b", n, got, e);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; btn = '0; we = 1'b0; idx = '0; val = '0;

        rs("reset_state");
        pr("idle_after_reset", 3'b000, 4'b0000);

        // default code, back-to-back presses
        st("t1_arm", 4'b0010);
        pr("t1_p0", 3'b001, 4'b0010);
        pr("t1_p1", 3'b010, 4'b0010);
        pr("t1_p2", 3'b100, 4'b0010);
        pr("t1_unlock", 3'b001, 4'b1000);
        pr("t1_idle", 3'b000, 4'b0000);

        // programmed code with 3-cycle gaps
        wr("t2_wr0", 2'd0, 3'b100);
        wr("t2_wr1", 2'd1, 3'b100);
        wr("t2_wr2", 2'd2, 3'b010);
        wr("t2_wr3", 2'd3, 3'b001);
        st("t2_arm", 4'b0010);
        pr("t2_p0", 3'b100, 4'b0010);
        for (int k = 0; k < 3; k++) pr("t2_gap", 3'b000, 4'b0010);
        pr("t2_p1", 3'b100, 4'b0010);
        for (int k = 0; k < 3; k++) pr("t2_gap", 3'b000, 4'b0010);
        pr("t2_p2", 3'b010, 4'b0010);
        for (int k = 0; k < 3; k++) pr("t2_gap", 3'b000, 4'b0010);
        pr("t2_unlock", 3'b001, 4'b1000);
        pr("t2_idle", 3'b000, 4'b0000);
        st("t2_old_arm", 4'b0010);
        pr("t2_old_fail", 3'b001, 4'b0100);
        pr("t2_old_idle", 3'b000, 4'b0000);
        rs("t2_reset");

        // multi-hot press after a correct one
        st("t3_arm", 4'b0010);
        pr("t3_p0", 3'b001, 4'b0010);
        pr("t3_multihot", 3'b011, 4'b0100);
        pr("t3_idle", 3'b000, 4'b0000);

        // write and re-Start while armed are ignored
        st("t4_arm", 4'b0010);
        vecs.push_back(mk("t4_wr_busy", 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 3'b100, 4'b0010));
        vecs.push_back(mk("t4_restart", 1'b0, 1'b1, 3'b010, 1'b0, 2'd0, 3'b000, 4'b0010));
        pr("t4_p2", 3'b100, 4'b0010);
        pr("t4_unlock", 3'b001, 4'b1000);
        pr("t4_idle", 3'b000, 4'b0000);

        // write and arm on the same edge: first compare uses new value
        vecs.push_back(mk("t5_arm_wr", 1'b0, 1'b1, 3'b000, 1'b1, 2'd0, 3'b010, 4'b0010));
        pr("t5_p0_new", 3'b010, 4'b0010);
        pr("t5_p1", 3'b010, 4'b0010);
        pr("t5_p2", 3'b100, 4'b0010);
        pr("t5_unlock", 3'b001, 4'b1000);
        pr("t5_idle", 3'b000, 4'b0000);

        // reset mid-sequence restores default code
        st("t6_arm", 4'b0010);
        pr("t6_p0", 3'b010, 4'b0010);
        pr("t6_p1", 3'b010, 4'b0010);
        rs("t6_reset_mid");
        st("t6_rearm", 4'b0010);
        pr("t6_p0_def", 3'b001, 4'b0010);
        pr("t6_p1_def", 3'b010, 4'b0010);
        pr("t6_p2_def", 3'b100, 4'b0010);
        pr("t6_unlock", 3'b001, 4'b1000);
        pr("t6_idle", 3'b000, 4'b0000);

        // held press counts twice; multi-hot first press; zero stored entry
        st("t7_arm", 4'b0010);
        pr("t7_p0", 3'b001, 4'b0010);
        pr("t7_held", 3'b001, 4'b0100);
        pr("t7_idle", 3'b000, 4'b0000);
        st("t7_arm2", 4'b0010);
        pr("t7_allhot", 3'b111, 4'b0100);
        pr("t7_idle2", 3'b000, 4'b0000);
        rs("t7_reset");
        wr("t7_wr_zero", 2'd0, 3'b000);
        st("t7_arm3", 4'b0010);
        pr("t7_zero_entry", 3'b001, 4'b0100);
        pr("t7_idle3", 3'b000, 4'b0000);
        rs("t7_reset2");

        foreach (vecs[i]) apply(vecs[i]);

        // Start held through DONE is ignored there and accepted one cycle later
        apply(mk("h_arm", 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("h_p0", 1'b0, 1'b0, 3'b001, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("h_p1", 1'b0, 1'b0, 3'b010, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("h_p2", 1'b0, 1'b0, 3'b100, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("h_unlock", 1'b0, 1'b1, 3'b001, 1'b0, 2'd0, 3'b000, 4'b1000));
        apply(mk("h_start_in_done", 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0000));
        apply(mk("h_start_in_idle", 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("h_fail_again", 1'b0, 1'b0, 3'b100, 1'b0, 2'd0, 3'b000, 4'b0100));
        apply(mk("h_idle", 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0000));

`ifdef SEQ_CODE_LOCKOUT_EN
        apply(mk("lk_reset", 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0000));
        for (int k = 0; k < 3; k++) begin
            apply(mk("lk_arm", 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0010));
            apply(mk("lk_fail", 1'b0, 1'b0, 3'b011, 1'b0, 2'd0, 3'b000, 4'b0100));
            if (k < 2) apply(mk("lk_idle", 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0000));
        end
        for (int k = 0; k < 16; k++)
            apply(mk("lk_locked", 1'b0, 1'b1, 3'b000, 1'b1, 2'd0, 3'b100, 4'b0001));
        apply(mk("lk_exit", 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0000));
        apply(mk("lk_arm_ok", 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("lk_p0", 1'b0, 1'b0, 3'b001, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("lk_p1", 1'b0, 1'b0, 3'b010, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("lk_p2", 1'b0, 1'b0, 3'b100, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("lk_unlock", 1'b0, 1'b0, 3'b001, 1'b0, 2'd0, 3'b000, 4'b1000));
        apply(mk("lk_idle2", 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0000));
        apply(mk("lk_arm_f", 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0010));
        apply(mk("lk_single_fail", 1'b0, 1'b0, 3'b010, 1'b0, 2'd0, 3'b000, 4'b0100));
        apply(mk("lk_no_lockout", 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'b0000));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
